// File: rtl/seq_elem_checker.sv
// -----------------------------------------------------------------------------
// seq_elem_checker
//
// Response checker for the storage-element stimulus path. It samples the
// {dut_rst_n, d} stimulus that drives an async-reset DFF and a sync-reset DFF,
// keeps a reference model of each flop, and compares their q outputs against
// the model on every clock of a run. After NUM_SAMPLES compared samples, or on
// the first mismatch when STOP_ON_ERR is set, it reports done/pass.
//
// Ports
//   clk         in   checker and DUT clock, posedge
//   rst         in   async active-high reset of the checker only
//   chk_en      in   level: start/continue a run, low returns to IDLE
//   dut_rst_n   in   active-low reset driven to both flops under test
//   d           in   data driven to both flops under test
//   q_asyn      in   q of the async-reset flop
//   q_syn       in   q of the sync-reset flop
//   err_pulse   out  one-cycle pulse for a mismatching sample
//   err_vec     out  {asyn_mismatch, syn_mismatch} of that sample, else 0
//   err_cnt     out  mismatching samples in this run (saturating)
//   sample_cnt  out  samples compared in this run (saturating)
//   first_err   out  sample index of the first mismatch, all-ones if none
//   done        out  high while in DONE
//   pass        out  done with no mismatches
// -----------------------------------------------------------------------------
module seq_elem_checker #(
    parameter int NUM_SAMPLES = 7,
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             dut_rst_n,
    input  logic             d,
    input  logic             q_asyn,
    input  logic             q_syn,
    output logic             err_pulse,
    output logic [1:0]       err_vec,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] first_err,
    output logic             done,
    output logic             pass
);

    // The run length is tracked separately from sample_cnt so that a narrow,
    // saturated sample_cnt still lets the run finish after NUM_SAMPLES.
    localparam int               RUN_W    = $clog2(NUM_SAMPLES + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               exp_syn_r;
    logic               exp_asyn_r;
    logic [RUN_W-1:0]   run_cnt_r;
    logic               err_pulse_r;
    logic [1:0]         err_vec_r;
    logic [CNT_W-1:0]   err_cnt_r;
    logic [CNT_W-1:0]   sample_cnt_r;
    logic [CNT_W-1:0]   first_err_r;
    logic               done_r;
    logic               pass_r;

    logic               asyn_ref_s;
    logic               mis_asyn_s;
    logic               mis_syn_s;
    logic               mis_any_s;
    logic               do_cmp_s;
    logic               err_free_nxt_s;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Compare logic and next-state decode.
    always_comb begin
        state_nxt_s    = state_r;
        // An asserted dut_rst_n clears the async flop immediately, so it
        // overrides the model taken at the previous edge.
        asyn_ref_s     = dut_rst_n ? exp_asyn_r : 1'b0;
        // Case inequality: anything but an exact 0/1 match is a mismatch.
        mis_asyn_s     = (q_asyn !== asyn_ref_s);
        mis_syn_s      = (q_syn !== exp_syn_r);
        mis_any_s      = mis_asyn_s | mis_syn_s;
        do_cmp_s       = (state_r == CHECK) && chk_en;
        err_free_nxt_s = (err_cnt_r == CNT_ZERO) && !(do_cmp_s && mis_any_s);
        case (state_r)
            IDLE: begin
                if (chk_en) state_nxt_s = ARM;
                else        state_nxt_s = IDLE;
            end
            ARM: begin
                if (chk_en) state_nxt_s = CHECK;
                else        state_nxt_s = IDLE;
            end
            CHECK: begin
                if (!chk_en)                                         state_nxt_s = IDLE;
                else if ((run_cnt_r == RUN_LAST) || (STOP_ON_ERR && mis_any_s)) state_nxt_s = DONE;
                else                                                 state_nxt_s = CHECK;
            end
            DONE: begin
                if (chk_en) state_nxt_s = DONE;
                else        state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, flop models, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            exp_syn_r    <= 1'b0;
            exp_asyn_r   <= 1'b0;
            run_cnt_r    <= {RUN_W{1'b0}};
            err_pulse_r  <= 1'b0;
            err_vec_r    <= 2'b00;
            err_cnt_r    <= CNT_ZERO;
            sample_cnt_r <= CNT_ZERO;
            first_err_r  <= CNT_MAX;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            err_pulse_r <= 1'b0;
            err_vec_r   <= 2'b00;
            done_r      <= (state_nxt_s == DONE);
            pass_r      <= (state_nxt_s == DONE) && err_free_nxt_s;

            // A new run starts with cleared counters; after an abort they
            // keep their values until this point.
            if ((state_r == IDLE) && chk_en) begin
                run_cnt_r    <= {RUN_W{1'b0}};
                err_cnt_r    <= CNT_ZERO;
                sample_cnt_r <= CNT_ZERO;
                first_err_r  <= CNT_MAX;
            end

            if ((state_r == ARM) || (state_r == CHECK)) begin
                exp_syn_r  <= dut_rst_n ? d : 1'b0;
                exp_asyn_r <= dut_rst_n ? d : 1'b0;
            end

            if (do_cmp_s) begin
                sample_cnt_r <= sat_inc(sample_cnt_r);
                run_cnt_r    <= run_cnt_r + RUN_W'(1);
                if (mis_any_s) begin
                    err_pulse_r <= 1'b1;
                    err_vec_r   <= {mis_asyn_s, mis_syn_s};
                    err_cnt_r   <= sat_inc(err_cnt_r);
                    // err_cnt==0 marks "no mismatch yet" even when the
                    // all-ones sentinel is also a legal sample index.
                    if (err_cnt_r == CNT_ZERO) begin
                        first_err_r <= sample_cnt_r;
                    end
                end
            end
        end
    end

    assign err_pulse  = err_pulse_r;
    assign err_vec    = err_vec_r;
    assign err_cnt    = err_cnt_r;
    assign sample_cnt = sample_cnt_r;
    assign first_err  = first_err_r;
    assign done       = done_r;
    assign pass       = pass_r;

endmodule
